// File: rtl/alu_issue_wb_pkg.sv
// Shared definitions for the execute-stage issue/write-back sequencer:
// opcodes, instruction field positions, FSM encoding and flag helper.
package alu_issue_wb_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_NOT = 4'b0001,
    OP_SUB = 4'b0010,
    OP_AND = 4'b0011,
    OP_OR  = 4'b0100,
    OP_XOR = 4'b0101,
    OP_MUL = 4'b0110,
    OP_DIV = 4'b0111,
    OP_SHL = 4'b1000,
    OP_SHR = 4'b1001,
    OP_CMP = 4'b1010,
    OP_LD  = 4'b1011
  } op_e;

  // Instruction field positions
  localparam int OP_HI    = 15;
  localparam int OP_LO    = 12;
  localparam int DR_HI    = 11;
  localparam int DR_LO    = 9;
  localparam int MODE_BIT = 8;
  localparam int SR_HI    = 7;
  localparam int SR_LO    = 5;
  localparam int IMM_HI   = 7;
  localparam int IMM_LO   = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_e;

  // Condition code {n,z,p} for a 16-bit value; exactly one bit is set.
  function automatic logic [2:0] nzp_of(input logic [15:0] v);
    if (v[15])
      return 3'b100;
    else if (v == 16'h0000)
      return 3'b010;
    else
      return 3'b001;
  endfunction

endpackage

// File: rtl/alu_issue_wb_if.sv
// Instruction handshake plus the bus towards the combinational ALU.
// master = upstream/ALU side, slave = the sequencer.
interface alu_issue_wb_if #(parameter int W = 16);
  logic         instr_valid;
  logic         instr_ready;
  logic [W-1:0] instr;
  logic [W-1:0] alu_opcode;
  logic [W-1:0] alu_regA;
  logic [W-1:0] alu_regB;
  logic [W-1:0] alu_res;

  modport master (
    output instr_valid, instr, alu_res,
    input  instr_ready, alu_opcode, alu_regA, alu_regB
  );

  modport slave (
    input  instr_valid, instr, alu_res,
    output instr_ready, alu_opcode, alu_regA, alu_regB
  );
endinterface

// File: rtl/reg_file_8x16.sv
// General register file: two combinational operand reads, one debug read,
// one synchronous write, asynchronous clear to zero.
module reg_file_8x16 #(
  parameter int NREG = 8,
  parameter int W    = 16,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [AW-1:0] i_ra_addr,
  output logic [W-1:0]  o_ra_data,
  input  logic [AW-1:0] i_rb_addr,
  output logic [W-1:0]  o_rb_data,
  input  logic [AW-1:0] i_dbg_addr,
  output logic [W-1:0]  o_dbg_data,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata
);

  logic [W-1:0] r_mem [NREG];

  assign o_ra_data  = r_mem[i_ra_addr];
  assign o_rb_data  = r_mem[i_rb_addr];
  assign o_dbg_data = r_mem[i_dbg_addr];

  // Storage: cleared on reset, single write port otherwise
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

endmodule

// File: rtl/alu_issue_wb.sv
// Execute-stage sequencer: accepts an instruction, reads operands, drives the
// ALU, captures its result and retires it into the register file and flags.
module alu_issue_wb
  import alu_issue_wb_pkg::*;
#(
  parameter int NREG = 8,
  parameter int W    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  alu_issue_wb_if.slave            bus,
  output logic                     n,
  output logic                     z,
  output logic                     p,
  output logic                     done,
  output logic                     illegal,
  input  logic [$clog2(NREG)-1:0]  dbg_addr,
  output logic [W-1:0]             dbg_data
);

  localparam int AW = $clog2(NREG);

  state_e       r_state;
  logic [W-1:0] r_instr;
  logic [W-1:0] r_alu_opcode;
  logic [W-1:0] r_alu_a;
  logic [W-1:0] r_alu_b;
  logic [W-1:0] r_res_q;
  logic [W-1:0] r_cmp_q;
  logic         r_n, r_z, r_p;
  logic         r_done;
  logic         r_illegal;
  logic         r_ready;

  logic [W-1:0] w_rd_a;
  logic [W-1:0] w_rd_b;
  logic [3:0]   w_op;
  logic         w_is_alu;
  logic         w_is_cmp;
  logic         w_is_ld;
  logic         w_is_illegal;
  logic         w_we;
  logic [W-1:0] w_wdata;
  logic         w_flag_upd;
  logic [2:0]   w_flags;

  reg_file_8x16 #(.NREG(NREG), .W(W), .AW(AW)) u_rf (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_ra_addr  (r_instr[DR_HI:DR_LO]),
    .o_ra_data  (w_rd_a),
    .i_rb_addr  (r_instr[SR_HI:SR_LO]),
    .o_rb_data  (w_rd_b),
    .i_dbg_addr (dbg_addr),
    .o_dbg_data (dbg_data),
    .i_we       (w_we),
    .i_waddr    (r_alu_opcode[DR_HI:DR_LO]),
    .i_wdata    (w_wdata)
  );

  // Retire decode works from the held ALU opcode, which stays valid through WB
  // even when the next instruction is being latched in the same cycle.
  always_comb begin
    w_op         = r_alu_opcode[OP_HI:OP_LO];
    w_is_alu     = (w_op <= OP_SHR);
    w_is_cmp     = (w_op == OP_CMP);
    w_is_ld      = (w_op == OP_LD);
    w_is_illegal = w_op[3] & w_op[2];
    w_we         = (r_state == WB) && (w_is_alu || w_is_ld);
    w_flag_upd   = (r_state == WB) && (w_is_alu || w_is_cmp);
    w_flags      = nzp_of(w_is_cmp ? r_cmp_q : r_res_q);
    if (w_is_ld)
      w_wdata = r_alu_opcode[MODE_BIT] ? r_alu_b
                                       : {8'h00, r_alu_opcode[IMM_HI:IMM_LO]};
    else
      w_wdata = r_res_q;
  end

  // Sequencer FSM with registered handshake, ALU drive, flags and pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_instr      <= '0;
      r_alu_opcode <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_n          <= 1'b0;
      r_z          <= 1'b1;
      r_p          <= 1'b0;
      r_done       <= 1'b0;
      r_illegal    <= 1'b0;
      r_ready      <= 1'b1;
    end else begin
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.instr_valid) begin
            r_instr <= bus.instr;
            r_ready <= 1'b0;
            r_state <= READ;
          end
        end
        READ: begin
          r_alu_opcode <= r_instr;
          r_alu_a      <= w_rd_a;
          r_alu_b      <= w_rd_b;
          r_state      <= EXEC;
        end
        EXEC: begin
          r_done    <= 1'b1;
          r_illegal <= w_is_illegal;
          r_ready   <= 1'b1;
          r_state   <= WB;
        end
        WB: begin
          if (w_flag_upd) {r_n, r_z, r_p} <= w_flags;
          if (bus.instr_valid) begin
            r_instr <= bus.instr;
            r_ready <= 1'b0;
            r_state <= READ;
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Capture the settled ALU result and the A-B comparison in EXEC
  always_ff @(posedge clk) begin
    if (r_state == EXEC) begin
      r_res_q <= bus.alu_res;
      r_cmp_q <= r_alu_a + ~r_alu_b + W'(1);
    end
  end

  assign bus.instr_ready = r_ready;
  assign bus.alu_opcode  = r_alu_opcode;
  assign bus.alu_regA    = r_alu_a;
  assign bus.alu_regB    = r_alu_b;
  assign n               = r_n;
  assign z               = r_z;
  assign p               = r_p;
  assign done            = r_done;
  assign illegal         = r_illegal;

endmodule

// File: tb/tb_alu_issue_wb.sv
// Directed bench for alu_issue_wb; the bench also plays the combinational ALU.
module tb_alu_issue_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        n, z, p, done, illegal;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic [15:0] alu_res_m;

  int ntests = 0;
  int nfail  = 0;
  int lat, nd, t0, t1, npulse;
  logic        ill;
  logic [15:0] ea, eb;

  alu_issue_wb_if bus ();

  alu_issue_wb dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .n        (n),
    .z        (z),
    .p        (p),
    .done     (done),
    .illegal  (illegal),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  // Reference ALU on the far side of the interface
  always_comb begin
    alu_res_m = 16'h0000;
    case (bus.alu_opcode[15:12])
      4'h0: alu_res_m = bus.alu_regA + bus.alu_regB;
      4'h1: alu_res_m = ~bus.alu_regA;
      4'h2: alu_res_m = bus.alu_regA - bus.alu_regB;
      4'h3: alu_res_m = bus.alu_regA & bus.alu_regB;
      4'h4: alu_res_m = bus.alu_regA | bus.alu_regB;
      4'h5: alu_res_m = bus.alu_regA ^ bus.alu_regB;
      4'h6: alu_res_m = bus.alu_regA * bus.alu_regB;
      4'h7: alu_res_m = (bus.alu_regB == 16'h0) ? 16'hFFFF : bus.alu_regA / bus.alu_regB;
      4'h8: alu_res_m = bus.alu_regA << bus.alu_regB[3:0];
      4'h9: alu_res_m = bus.alu_regA >> bus.alu_regB[3:0];
      default: alu_res_m = 16'hDEAD;
    endcase
  end
  assign bus.alu_res = alu_res_m;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] v);
    dbg_addr = a;
    #1;
    v = dbg_data;
  endtask

  // Offer one instruction, wait for its done pulse, stop one cycle after WB
  task automatic issue(input logic [15:0] ins, output int l, output logic il,
                       output logic [15:0] a, output logic [15:0] b);
    int k;
    @(negedge clk);
    k = 0;
    while (!bus.instr_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    l = 0; il = 1'b0; a = '0; b = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 2) begin
        a = bus.alu_regA;
        b = bus.alu_regB;
      end
      if (done) begin
        l  = c;
        il = illegal;
        break;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] v;
    rst_n           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'h0000;
    dbg_addr        = 3'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_flags", 16'({n, z, p}), 16'h0002);
    check("rst_done", 16'(done), 16'h0000);
    check("rst_illegal", 16'(illegal), 16'h0000);
    check("rst_opcode", bus.alu_opcode, 16'h0000);
    check("rst_regA", bus.alu_regA, 16'h0000);
    check("rst_regB", bus.alu_regB, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 16'(bus.instr_ready), 16'h0001);
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), v);
      check("rst_rf", v, 16'h0000);
    end

    // LD R1, #5
    issue(16'hB205, lat, ill, ea, eb);
    check("ld_latency", 16'(lat), 16'd3);
    rd(3'd1, v);
    check("ld_r1", v, 16'h0005);
    check("ld_flags", 16'({n, z, p}), 16'h0002);
    check("ld_done_drop", 16'(done), 16'h0000);

    // LD R2, #3 ; ADD R1,R2
    issue(16'hB403, lat, ill, ea, eb);
    issue(16'h0240, lat, ill, ea, eb);
    check("add_latency", 16'(lat), 16'd3);
    check("add_exec_A", ea, 16'h0005);
    check("add_exec_B", eb, 16'h0003);
    rd(3'd1, v);
    check("add_r1", v, 16'h0008);
    check("add_flags", 16'({n, z, p}), 16'h0001);
    check("add_opcode_hold", bus.alu_opcode, 16'h0240);

    // CMP 3 vs 5 -> negative, no write
    issue(16'hB203, lat, ill, ea, eb);
    issue(16'hB405, lat, ill, ea, eb);
    issue(16'hA240, lat, ill, ea, eb);
    check("cmp_lt_flags", 16'({n, z, p}), 16'h0004);
    rd(3'd1, v);
    check("cmp_r1_kept", v, 16'h0003);

    // LD keeps flags; CMP 5 vs 5 -> zero
    issue(16'hB205, lat, ill, ea, eb);
    check("ld_keeps_flags", 16'({n, z, p}), 16'h0004);
    issue(16'hA240, lat, ill, ea, eb);
    check("cmp_eq_flags", 16'({n, z, p}), 16'h0002);
    rd(3'd1, v);
    check("cmp_eq_r1", v, 16'h0005);

    // Back-to-back: LD R3,#FF then dependent NOT R3
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = 16'hB6FF;
    @(posedge clk);
    #1 bus.instr = 16'h1600;
    nd = 0; t0 = 0; t1 = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (done) begin
        if (nd == 0) t0 = c; else t1 = c;
        nd++;
        if (nd == 1) begin
          @(posedge clk);
          #1 bus.instr_valid = 1'b0;
        end
      end
    end
    check("b2b_pulses", 16'(nd), 16'd2);
    check("b2b_first", 16'(t0), 16'd3);
    check("b2b_gap", 16'(t1 - t0), 16'd3);
    rd(3'd3, v);
    check("b2b_r3", v, 16'hFF00);
    check("b2b_flags", 16'({n, z, p}), 16'h0004);

    // LD R4 from register R3 (mode=1)
    issue(16'hB960, lat, ill, ea, eb);
    rd(3'd4, v);
    check("ldreg_r4", v, 16'hFF00);
    check("ldreg_flags", 16'({n, z, p}), 16'h0004);

    // Illegal opcode
    issue(16'hC000, lat, ill, ea, eb);
    check("ill_latency", 16'(lat), 16'd3);
    check("ill_pulse", 16'(ill), 16'h0001);
    check("ill_drop", 16'(illegal), 16'h0000);
    check("ill_flags", 16'({n, z, p}), 16'h0004);
    rd(3'd0, v);
    check("ill_r0", v, 16'h0000);
    rd(3'd1, v);
    check("ill_r1", v, 16'h0005);

    // Reset during EXEC of ADD R1,R2
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = 16'h0240;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_done", 16'(done), 16'h0000);
    check("mrst_flags", 16'({n, z, p}), 16'h0002);
    rd(3'd1, v);
    check("mrst_r1", v, 16'h0000);
    rd(3'd3, v);
    check("mrst_r3", v, 16'h0000);
    @(negedge clk);
    rst_n  = 1'b1;
    npulse = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done) npulse++;
    end
    check("mrst_no_done", 16'(npulse), 16'h0000);
    check("mrst_ready", 16'(bus.instr_ready), 16'h0001);
    rd(3'd1, v);
    check("mrst_r1_after", v, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
